// File: rtl/factor_display_sequencer.sv
// Factor display sequencer: walks a captured factor mask and shows
// each factor on a 7-segment display with dwell and gap timing.
module factor_display_sequencer #(
  parameter int DWELL = 1000,
  parameter int GAP   = 100,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] factors,
  output logic [6:0] segments,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAPS,
    NONE
  } state_t;

  localparam logic [CW-1:0] DW_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] GP_END =
    (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [6:0] DASH = 7'h40;

  state_t        state;
  logic [7:0]    mask;
  logic [7:0]    nxt;
  logic [CW-1:0] cnt;

  // lowest set bit wins, so the walk is ascending
  function automatic logic [6:0] seg_of(
    input logic [7:0] m
  );
    priority case (1'b1)
      m[0]:    seg_of = 7'h5B;
      m[1]:    seg_of = 7'h4F;
      m[2]:    seg_of = 7'h66;
      m[3]:    seg_of = 7'h6D;
      m[4]:    seg_of = 7'h7D;
      m[5]:    seg_of = 7'h07;
      m[6]:    seg_of = 7'h7F;
      m[7]:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  assign nxt = mask & (mask - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      cnt      <= '0;
      segments <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      mask <= factors;
      cnt  <= '0;
      done <= 1'b0;
      busy <= 1'b1;
      if (factors != 8'd0) begin
        state    <= SHOW;
        segments <= seg_of(factors);
      end else begin
        state    <= NONE;
        segments <= DASH;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          segments <= '0;
        end
        SHOW: begin
          if (cnt == DW_END) begin
            mask <= nxt;
            cnt  <= '0;
            if (GAP > 0) begin
              state    <= GAPS;
              segments <= '0;
            end else if (nxt != 8'd0) begin
              state    <= SHOW;
              segments <= seg_of(nxt);
            end else begin
              state    <= IDLE;
              segments <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAPS: begin
          if (cnt == GP_END) begin
            cnt <= '0;
            if (mask != 8'd0) begin
              state    <= SHOW;
              segments <= seg_of(mask);
            end else begin
              state    <= IDLE;
              segments <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NONE: begin
          if (cnt == DW_END) begin
            cnt      <= '0;
            state    <= IDLE;
            segments <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_factor_display_sequencer.sv
// Randomised bench for factor_display_sequencer against a
// per-cycle expected-output model built from the factor mask.
module tb_factor_display_sequencer;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load0, load1;
  logic [7:0] f0, f1;
  logic [6:0] seg0, seg1;
  logic       busy0, busy1, done0, done1;

  int passed = 0;
  int total  = 0;

  logic [6:0] codes [10] = '{
    7'h00, 7'h00, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  always #5 clk = ~clk;

  factor_display_sequencer #(
    .DWELL(DW), .GAP(2), .CW(8)
  ) dut0 (
    .clk(clk), .rst(rst), .load(load0),
    .factors(f0), .segments(seg0),
    .busy(busy0), .done(done0)
  );

  factor_display_sequencer #(
    .DWELL(DW), .GAP(0), .CW(8)
  ) dut1 (
    .clk(clk), .rst(rst), .load(load1),
    .factors(f1), .segments(seg1),
    .busy(busy1), .done(done1)
  );

  function automatic logic [8:0] obs(input bit sel);
    return sel ? {seg1, busy1, done1}
               : {seg0, busy0, done0};
  endfunction

  task automatic load_dut(
    input bit sel, input logic [7:0] m, input bit now
  );
    if (!now) @(negedge clk);
    if (sel) begin load1 = 1'b1; f1 = m; end
    else     begin load0 = 1'b1; f0 = m; end
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  // expected {seg,busy,done} per cycle from cycle k+1
  task automatic check_seq(
    input bit sel, input logic [7:0] m,
    input bit toggle, input int tail, input string name
  );
    logic [8:0] q[$];
    logic [8:0] got;
    int gap;
    gap = sel ? 0 : 2;
    if (m == 8'd0) begin
      repeat (DW) q.push_back({7'h40, 2'b10});
    end else begin
      for (int f = 2; f <= 9; f++) begin
        if (m[f-2]) begin
          repeat (DW) q.push_back({codes[f], 2'b10});
          repeat (gap) q.push_back({7'h00, 2'b10});
        end
      end
    end
    q.push_back({7'h00, 2'b01});
    repeat (tail) q.push_back({7'h00, 2'b00});
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (toggle) begin
        f0 = 8'($urandom);
        f1 = 8'($urandom);
      end
      got = obs(sel);
      total++;
      if (got !== q[i])
        $display("FAIL %s cyc%0d m=%02h got=%03h exp=%03h",
                 name, i, m, got, q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    load0 = 1'b0; load1 = 1'b0;
    f0 = 8'hFF; f1 = 8'hFF;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (obs(s[0]) !== 9'h000)
        $display("FAIL reset dut%0d got=%03h exp=000",
                 s, obs(s[0]));
      else passed++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs(1'b0) !== 9'h000)
      $display("FAIL reset_idle got=%03h exp=000", obs(1'b0));
    else passed++;
  endtask

  task automatic test_plan;
    load_dut(1'b0, 8'h45, 1'b0);
    check_seq(1'b0, 8'h45, 1'b0, 2, "plan45");
    load_dut(1'b0, 8'h00, 1'b0);
    check_seq(1'b0, 8'h00, 1'b0, 2, "dash");
    load_dut(1'b1, 8'h81, 1'b0);
    check_seq(1'b1, 8'h81, 1'b0, 2, "gap0_81");
  endtask

  task automatic test_abort;
    load_dut(1'b0, 8'h45, 1'b0);
    repeat (6) @(negedge clk);
    total++;
    if (seg0 !== 7'h66 || busy0 !== 1'b1)
      $display("FAIL abort_pre seg=%02h busy=%b exp=66/1",
               seg0, busy0);
    else passed++;
    load_dut(1'b0, 8'h02, 1'b0);
    check_seq(1'b0, 8'h02, 1'b0, 4, "abort");
  endtask

  task automatic test_async_reset;
    load_dut(1'b0, 8'h45, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs(1'b0) !== 9'h000)
      $display("FAIL async_rst got=%03h exp=000", obs(1'b0));
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (obs(1'b0) !== 9'h000)
        $display("FAIL post_rst cyc%0d got=%03h exp=000",
                 i, obs(1'b0));
      else passed++;
    end
  endtask

  task automatic test_toggle;
    load_dut(1'b0, 8'h29, 1'b0);
    check_seq(1'b0, 8'h29, 1'b1, 1, "toggle");
  endtask

  task automatic test_back_to_back;
    load_dut(1'b1, 8'h10, 1'b0);
    check_seq(1'b1, 8'h10, 1'b0, 0, "b2b_a");
    load_dut(1'b1, 8'hC0, 1'b1);
    check_seq(1'b1, 8'hC0, 1'b0, 2, "b2b_b");
  endtask

  task automatic test_random;
    bit sel;
    logic [7:0] m;
    for (int n = 0; n < 30; n++) begin
      sel = 1'($urandom);
      m = ($urandom_range(0, 5) == 0) ? 8'h00
                                      : 8'($urandom);
      load_dut(sel, m, 1'b0);
      check_seq(sel, m, 1'b1, $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset;
    test_plan;
    test_abort;
    test_async_reset;
    test_toggle;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/factor_display_sequencer.md
Name: factor_display_sequencer

Overview:
- Sequential stage directly downstream of the combinational factorizer.
- Captures the 8-bit factor mask (bit i set means divisible by i+2, for 2..9).
- Steps through each set bit in ascending order and drives a 7-segment pattern for that factor for a fixed dwell time, with a blank gap between digits.
- Shows a dash when no factor bit is set; signals completion with a one-cycle done pulse.

Parameters:
- DWELL, 1000: cycles each digit or the dash is shown; must be >= 1.
- GAP, 100: blank cycles after each digit; 0 means no gap.
- CW, 16: width of the internal cycle counter; must satisfy 2^CW > max(DWELL, GAP).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  capture factors and start a sequence.
- factors  input  8  factor mask from the factorizer, sampled only when load=1.
- segments  output  7  {g,f,e,d,c,b,a}, active-high, registered.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE, mask=0, counter=0, segments=0x00, busy=0, done=0.
- States:
  - IDLE: segments=0x00, busy=0.
  - SHOW: segments show the lowest set mask bit, busy=1.
  - GAP: segments=0x00, busy=1.
  - NONE: segments=0x40 (dash), busy=1.
- Segment codes: 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. All outputs are registered. Segments change on the same edge as the state change.
- load=1 at edge k, in any state:
  - mask <= factors, counter <= 0, done <= 0.
  - If factors!=0, state <= SHOW; otherwise state <= NONE.
  - Segments are valid from cycle k+1.
- load has priority over every other transition, so load mid-sequence restarts cleanly with the new mask. load while IDLE with done high suppresses nothing: done still drops after its one cycle.
- SHOW:
  - Counter counts 0..DWELL-1.
  - On the edge where counter=DWELL-1: clear the lowest set mask bit (mask & (mask-1)) and reset the counter.
  - If GAP>0, go to GAP. If GAP=0, go directly to SHOW for the next set bit, or finish if no bit remains.
- GAP:
  - Counter counts 0..GAP-1.
  - At GAP-1: go to SHOW if mask!=0, else finish.
  - The gap also follows the last digit.
- NONE: shows the dash for DWELL cycles, then finish. No gap.
- Finish:
  - state <= IDLE, busy <= 0, done <= 1 for exactly the first IDLE cycle.
  - Segments are 0x00 in that cycle.
- Sequence length with N set bits:
  - N>0: N*(DWELL+GAP) cycles of busy.
  - N=0: DWELL cycles of busy.
- factors is ignored whenever load=0; the captured mask is not affected by later input changes.
- rst asserted mid-sequence: all outputs go to reset values immediately. No done pulse.
- Counter never wraps: it is always cleared at the terminal count.

Test Plan:
- DWELL=4, GAP=2; load with factors=0x45 (number 8) -> from k+1: 4 cycles 0x5B, 2 cycles 0x00, 4 cycles 0x66, 2 cycles 0x00, 4 cycles 0x7F, 2 cycles 0x00. busy high for 18 cycles, then done=1 for 1 cycle with busy=0.
- load with factors=0x00 -> 4 cycles segments=0x40, busy=1; then done pulse; segments=0x00.
- GAP=0, factors=0x81 (2 and 9) -> 4 cycles 0x5B, then immediately 4 cycles 0x6F, then done. Busy is 8 cycles.
- During the second digit of 0x45, assert load with factors=0x02 -> next cycle shows 0x4F for 4 cycles, then 2 blank cycles, then one done pulse. No done from the aborted sequence.
- Assert rst asynchronously mid-SHOW (not on a clock edge) -> segments=0x00, busy=0, done=0 immediately. After release with no load, stays IDLE.
- Toggle factors while busy with load=0 -> displayed sequence unchanged from the captured mask.
